// File: rtl/mem_access_unit.sv
// Memory-stage access sequencer: alignment check, MMU translation handshake,
// byte-lane bus transaction with timeout, and load data alignment/extension.
package mau_pkg;
  typedef enum logic {
    MEM_ACCESS_R = 1'b0,
    MEM_ACCESS_W = 1'b1
  } MEM_ACCESS_T;

  typedef enum logic [1:0] {
    MMU_EXC_NONE     = 2'd0,
    MMU_EXC_MISS     = 2'd1,
    MMU_EXC_INVALID  = 2'd2,
    MMU_EXC_MODIFIED = 2'd3
  } MMU_EXCEPTION_T;
endpackage

module mem_access_unit
  import mau_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic           clk,
  input  logic           res,
  input  logic           cpu_req,
  input  logic [31:0]    cpu_vAddr,
  input  MEM_ACCESS_T    cpu_accessType,
  input  logic [1:0]     cpu_size,
  input  logic           cpu_signed,
  input  logic [31:0]    cpu_wdata,
  output logic [31:0]    cpu_rdata,
  output logic           cpu_ready,
  output logic [2:0]     cpu_fault,
  output logic           busy,
  output logic           mmu_addrValid,
  output logic [31:0]    mmu_vAddr,
  output MEM_ACCESS_T    mmu_accessType,
  input  logic [31:0]    mmu_pAddr,
  input  MMU_EXCEPTION_T mmu_exception,
  output logic           bus_req,
  output logic           bus_we,
  output logic [31:0]    bus_addr,
  output logic [3:0]     bus_be,
  output logic [31:0]    bus_wdata,
  input  logic [31:0]    bus_rdata,
  input  logic           bus_ack
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_XLATE = 3'd1,
    S_CHECK = 3'd2,
    S_BUS   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [2:0] FLT_NONE     = 3'd0;
  localparam logic [2:0] FLT_MISS     = 3'd1;
  localparam logic [2:0] FLT_INVALID  = 3'd2;
  localparam logic [2:0] FLT_MODIFIED = 3'd3;
  localparam logic [2:0] FLT_ADDR     = 3'd4;
  localparam logic [2:0] FLT_BUS      = 3'd5;

  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  state_t      w_next;
  logic [1:0]  r_size;
  logic        r_signed;
  logic [31:0] r_wdata;
  logic [31:0] r_cnt;
  logic        w_misaligned;
  logic        w_timeout;
  logic [31:0] w_paddr;

  function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'd0:    lane_be = 4'b0001 << off;
      2'd1:    lane_be = 4'b0011 << off;
      default: lane_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] wd);
    case (size)
      2'd0:    lane_wdata = {4{wd[7:0]}};
      2'd1:    lane_wdata = {2{wd[15:0]}};
      default: lane_wdata = wd;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [1:0] size, input logic sgn,
                                              input logic [1:0] off, input logic [31:0] rd);
    logic [31:0] sh;
    sh = rd >> {off, 3'b000};
    case (size)
      2'd0:    load_extend = {{24{sgn & sh[7]}}, sh[7:0]};
      2'd1:    load_extend = {{16{sgn & sh[15]}}, sh[15:0]};
      default: load_extend = sh;
    endcase
  endfunction

  always_comb begin
    w_misaligned = 1'b0;
    case (cpu_size)
      2'd0:    w_misaligned = 1'b0;
      2'd1:    w_misaligned = cpu_vAddr[0];
      2'd2:    w_misaligned = |cpu_vAddr[1:0];
      default: w_misaligned = 1'b1;
    endcase
  end

  // Sub-word offset comes from the virtual address; the bus address is word-aligned.
  assign w_paddr   = mmu_pAddr & 32'hFFFF_FFFC;
  assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_cnt == TO_LAST) && !bus_ack;

  always_ff @(posedge clk) begin
    if (res) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    busy          = 1'b1;
    mmu_addrValid = 1'b0;
    bus_req       = 1'b0;
    bus_we        = 1'b0;
    cpu_ready     = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (cpu_req) w_next = w_misaligned ? S_DONE : S_XLATE;
      end
      S_XLATE: begin
        mmu_addrValid = 1'b1;
        w_next        = S_CHECK;
      end
      S_CHECK: begin
        w_next = (mmu_exception == MMU_EXC_NONE) ? S_BUS : S_DONE;
      end
      S_BUS: begin
        bus_req = 1'b1;
        bus_we  = (mmu_accessType == MEM_ACCESS_W);
        if (bus_ack || w_timeout) w_next = S_DONE;
      end
      S_DONE: begin
        cpu_ready = 1'b1;
        w_next    = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      mmu_vAddr      <= '0;
      mmu_accessType <= MEM_ACCESS_R;
      r_size         <= '0;
      r_signed       <= 1'b0;
      r_wdata        <= '0;
      bus_addr       <= '0;
      bus_be         <= '0;
      bus_wdata      <= '0;
      cpu_rdata      <= '0;
      cpu_fault      <= FLT_NONE;
      r_cnt          <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cpu_req) begin
            mmu_vAddr      <= cpu_vAddr;
            mmu_accessType <= cpu_accessType;
            r_size         <= cpu_size;
            r_signed       <= cpu_signed;
            r_wdata        <= cpu_wdata;
            cpu_fault      <= w_misaligned ? FLT_ADDR : FLT_NONE;
          end
        end
        S_CHECK: begin
          case (mmu_exception)
            MMU_EXC_MISS:     cpu_fault <= FLT_MISS;
            MMU_EXC_INVALID:  cpu_fault <= FLT_INVALID;
            MMU_EXC_MODIFIED: cpu_fault <= FLT_MODIFIED;
            default: begin
              cpu_fault <= FLT_NONE;
              bus_addr  <= w_paddr;
              bus_be    <= lane_be(r_size, mmu_vAddr[1:0]);
              bus_wdata <= lane_wdata(r_size, r_wdata);
              r_cnt     <= '0;
            end
          endcase
        end
        S_BUS: begin
          // An ack on the final timeout cycle still completes successfully.
          if (bus_ack) begin
            if (mmu_accessType == MEM_ACCESS_R)
              cpu_rdata <= load_extend(r_size, r_signed, mmu_vAddr[1:0], bus_rdata);
          end else begin
            r_cnt <= r_cnt + 32'd1;
            if (w_timeout) cpu_fault <= FLT_BUS;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
